// File: rtl/can_pkg.sv
// Shared definitions for the CAN frame receiver.
// Contents:
//   rx_state_t      receiver FSM state encoding
//   ID_W, DLC_W     identifier and DLC field widths
//   DATA_W, CNT_W   data payload width and field bit-counter width
//   *_DEF           default parameter values for can_rx
//   clamp_len()     limit a DLC value to the supported byte count
package can_pkg;

    localparam int ID_W             = 11;
    localparam int DLC_W            = 4;
    localparam int DATA_W           = 64;
    localparam int CNT_W            = 7;
    localparam int EOF_BITS_DEF     = 7;
    localparam int MAX_BYTES_DEF    = 8;
    localparam int RECOVER_BITS_DEF = 11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_RTR,
        ST_IDE,
        ST_R0,
        ST_DLC,
        ST_DATA,
        ST_ACK_SLOT,
        ST_ACK_DELIM,
        ST_EOF,
        ST_ERROR
    } rx_state_t;

    function automatic logic [DLC_W-1:0] clamp_len(input logic [DLC_W-1:0] dlc,
                                                   input int max_bytes);
        if (int'(dlc) > max_bytes) begin
            return DLC_W'(max_bytes);
        end
        return dlc;
    endfunction

endpackage

// File: rtl/can_rx_shifter.sv
// Serial-in shadow register for one frame field (ID, DLC or data).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        zero the register and the field counter (start of frame)
//   en         sample bit_in this cycle
//   bit_in     serial bus bit
//   len        number of bits in the field
//   data       assembled field value
//   done       high on the cycle the last bit of the field is sampled
// BYTE_LSB_FIRST=0: plain MSB-first shift.
// BYTE_LSB_FIRST=1: byte k lands in data[8k+7:8k], each byte MSB first
//                   (requires W=64).
module can_rx_shifter import can_pkg::*; #(
    parameter int W              = ID_W,
    parameter bit BYTE_LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    input  logic [CNT_W-1:0] len,
    output logic [W-1:0]     data,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign done = en && (cnt == len - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= done ? '0 : cnt + CNT_W'(1);
        end
    end

    generate
        if (BYTE_LSB_FIRST) begin : g_byte
            // Byte index from cnt[5:3]; bit 7 of each byte arrives first.
            logic [5:0] pos;
            assign pos = {cnt[5:3], ~cnt[2:0]};

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    data <= '0;
                end else if (en) begin
                    data[pos] <= bit_in;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    data <= '0;
                end else if (en) begin
                    data <= {data[W-2:0], bit_in};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/can_rx.sv
// Bit-serial CAN frame receiver (one bus bit per clk, no stuffing, no CRC).
// Frame: SOF, ID[11], RTR, IDE, r0, DLC[4], data, ACK slot, ACK delim, EOF.
// Optional build macro CAN_RX_ID_FILTER_EN adds FILTER_ID / FILTER_MASK
// acceptance filtering; rejected frames are tracked but neither ACKed nor
// committed.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   rx         bus level (0 = dominant)
//   ack_tx     ACK drive, 0 = dominant, low only in the ACK slot
//   rx_id, rx_rtr, rx_dlc, rx_data   held frame fields
//   rx_valid / rx_ready              consumer handshake
//   rx_busy    receiver not idle
//   form_err   one-cycle pulse on a form error
//   overrun    sticky, a held frame was overwritten
module can_rx import can_pkg::*; #(
    parameter int EOF_BITS     = EOF_BITS_DEF,
    parameter int MAX_BYTES    = MAX_BYTES_DEF,
    parameter int RECOVER_BITS = RECOVER_BITS_DEF
`ifdef CAN_RX_ID_FILTER_EN
    ,
    parameter logic [ID_W-1:0] FILTER_ID   = '0,
    parameter logic [ID_W-1:0] FILTER_MASK = '0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              ack_tx,
    output logic [ID_W-1:0]   rx_id,
    output logic              rx_rtr,
    output logic [DLC_W-1:0]  rx_dlc,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_busy,
    output logic              form_err,
    output logic              overrun
);

    rx_state_t        state;
    logic [7:0]       cnt;
    logic             rtr_q;
    logic             id_match;
    logic [CNT_W-1:0] data_bits;

    logic [ID_W-1:0]   id_sh;
    logic [DLC_W-1:0]  dlc_sh;
    logic [DATA_W-1:0] data_sh;
    logic              id_done, dlc_done, data_done;

    logic              sof;
    logic              commit;
    logic              handshake;
    logic [DLC_W-1:0]  dlc_full;
    logic [DLC_W-1:0]  dlc_clamped;

    assign sof       = (state == ST_IDLE) && !rx;
    assign handshake = rx_valid && rx_ready;
    assign commit    = (state == ST_EOF) && rx && (cnt == 8'(EOF_BITS - 1)) && id_match;

    // The final DLC bit is still on rx when the field completes.
    assign dlc_full    = {dlc_sh[DLC_W-2:0], rx};
    assign dlc_clamped = clamp_len(dlc_full, MAX_BYTES);

    assign ack_tx  = !((state == ST_ACK_SLOT) && id_match);
    assign rx_busy = (state != ST_IDLE);

`ifdef CAN_RX_ID_FILTER_EN
    logic [ID_W-1:0] id_full;
    assign id_full = {id_sh[ID_W-2:0], rx};
`endif

    can_rx_shifter #(.W(ID_W), .BYTE_LSB_FIRST(1'b0)) u_id (
        .clk    (clk),
        .rst    (rst),
        .clr    (sof),
        .en     (state == ST_ID),
        .bit_in (rx),
        .len    (CNT_W'(ID_W)),
        .data   (id_sh),
        .done   (id_done)
    );

    can_rx_shifter #(.W(DLC_W), .BYTE_LSB_FIRST(1'b0)) u_dlc (
        .clk    (clk),
        .rst    (rst),
        .clr    (sof),
        .en     (state == ST_DLC),
        .bit_in (rx),
        .len    (CNT_W'(DLC_W)),
        .data   (dlc_sh),
        .done   (dlc_done)
    );

    can_rx_shifter #(.W(DATA_W), .BYTE_LSB_FIRST(1'b1)) u_data (
        .clk    (clk),
        .rst    (rst),
        .clr    (sof),
        .en     (state == ST_DATA),
        .bit_in (rx),
        .len    (data_bits),
        .data   (data_sh),
        .done   (data_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rtr_q     <= 1'b0;
            id_match  <= 1'b0;
            data_bits <= '0;
            rx_id     <= '0;
            rx_rtr    <= 1'b0;
            rx_dlc    <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            form_err  <= 1'b0;
        end else begin
            form_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!rx) begin
                        state <= ST_ID;
                    end
                end
                ST_ID: begin
                    if (id_done) begin
                        state <= ST_RTR;
`ifdef CAN_RX_ID_FILTER_EN
                        id_match <= (((id_full ^ FILTER_ID) & FILTER_MASK) == '0);
`else
                        id_match <= 1'b1;
`endif
                    end
                end
                ST_RTR: begin
                    rtr_q <= rx;
                    state <= ST_IDE;
                end
                ST_IDE: state <= ST_R0;
                ST_R0:  state <= ST_DLC;
                ST_DLC: begin
                    if (dlc_done) begin
                        data_bits <= {dlc_clamped, 3'b000};
                        state     <= (dlc_clamped != '0) ? ST_DATA : ST_ACK_SLOT;
                    end
                end
                ST_DATA: begin
                    if (data_done) begin
                        state <= ST_ACK_SLOT;
                    end
                end
                ST_ACK_SLOT: state <= ST_ACK_DELIM;
                ST_ACK_DELIM: begin
                    cnt <= '0;
                    if (!rx) begin
                        form_err <= 1'b1;
                        state    <= ST_ERROR;
                    end else begin
                        state <= ST_EOF;
                    end
                end
                ST_EOF: begin
                    if (!rx) begin
                        form_err <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_ERROR;
                    end else if (cnt == 8'(EOF_BITS - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_ERROR: begin
                    if (!rx) begin
                        cnt <= '0;
                    end else if (cnt == 8'(RECOVER_BITS - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase

            if (handshake) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            // A same-cycle handshake is accept-then-load: valid stays set
            // and the overrun flag keeps its current value.
            if (commit) begin
                rx_id    <= id_sh;
                rx_rtr   <= rtr_q;
                rx_dlc   <= dlc_sh;
                rx_data  <= data_sh;
                rx_valid <= 1'b1;
                if (handshake) begin
                    overrun <= overrun;
                end else if (rx_valid) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_rx.sv
// Directed bench for can_rx. Frames are built bit by bit from field values,
// driven one bit per clock, and the held outputs are compared against
// hand-computed values. Build with CAN_RX_ID_FILTER_EN to add the filter
// scenario (FILTER_ID=0x100, FILTER_MASK=0x700); all other IDs are chosen
// to pass that filter.
module tb_can_rx;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        ack_tx;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_busy;
    logic        form_err;
    logic        overrun;

`ifdef CAN_RX_ID_FILTER_EN
    can_rx #(.FILTER_ID(11'h100), .FILTER_MASK(11'h700)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .ack_tx   (ack_tx),
        .rx_id    (rx_id),
        .rx_rtr   (rx_rtr),
        .rx_dlc   (rx_dlc),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_busy  (rx_busy),
        .form_err (form_err),
        .overrun  (overrun)
    );
`else
    can_rx dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .ack_tx   (ack_tx),
        .rx_id    (rx_id),
        .rx_rtr   (rx_rtr),
        .rx_dlc   (rx_dlc),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_busy  (rx_busy),
        .form_err (form_err),
        .overrun  (overrun)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    bit fq[$];
    int bit_idx;
    int ack_lows;
    int ack_idx;
    int ferr_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bus bit for a full clock; observe ack_tx/form_err mid-cycle.
    task automatic send_bit(input logic b);
        rx = b;
        @(negedge clk);
        if (ack_tx === 1'b0) begin
            ack_lows++;
            ack_idx = bit_idx;
        end
        if (form_err === 1'b1) ferr_cnt++;
        bit_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data, input int nbytes, input logic delim);
        fq.delete();
        fq.push_back(1'b0);
        for (int i = 10; i >= 0; i--) fq.push_back(id[i]);
        fq.push_back(rtr);
        fq.push_back(1'b0);
        fq.push_back(1'b0);
        for (int i = 3; i >= 0; i--) fq.push_back(dlc[i]);
        for (int b = 0; b < nbytes; b++)
            for (int i = 7; i >= 0; i--) fq.push_back(data[8*b+i]);
        fq.push_back(1'b1);
        fq.push_back(delim);
        for (int i = 0; i < 7; i++) fq.push_back(1'b1);
    endtask

    task automatic send_bits(input int n);
        bit_idx  = 0;
        ack_lows = 0;
        ack_idx  = -1;
        for (int i = 0; i < n && i < fq.size(); i++) send_bit(fq[i]);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        ferr_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_tx",   64'(ack_tx),   64'd1);
        chk("rst_valid",    64'(rx_valid), 64'd0);
        chk("rst_busy",     64'(rx_busy),  64'd0);
        chk("rst_overrun",  64'(overrun),  64'd0);
        chk("rst_form_err", 64'(form_err), 64'd0);
        chk("rst_id",       64'(rx_id),    64'd0);
        chk("rst_data",     rx_data,       64'd0);
        rst = 1'b0;
        idle(2);

        // Basic frame, two data bytes
        build_frame(11'h123, 1'b1, 4'd2, 64'h3CA5, 2, 1'b1);
        send_bits(fq.size() - 1);
        chk("f1_valid_before_last", 64'(rx_valid), 64'd0);
        send_bit(fq[fq.size()-1]);
        chk("f1_ack_lows", 64'(ack_lows), 64'd1);
        chk("f1_ack_idx",  64'(ack_idx),  64'd35);
        chk("f1_valid",    64'(rx_valid), 64'd1);
        chk("f1_id",       64'(rx_id),    64'h123);
        chk("f1_rtr",      64'(rx_rtr),   64'd1);
        chk("f1_dlc",      64'(rx_dlc),   64'd2);
        chk("f1_data",     rx_data,       64'h3CA5);
        chk("f1_busy",     64'(rx_busy),  64'd0);
        chk("f1_overrun",  64'(overrun),  64'd0);
        accept();
        chk("f1_valid_cleared", 64'(rx_valid), 64'd0);
        idle(2);

        // DLC = 0: ACK slot follows the DLC field directly
        build_frame(11'h1FF, 1'b0, 4'd0, 64'h0, 0, 1'b1);
        send_bits(fq.size());
        chk("f2_ack_lows", 64'(ack_lows), 64'd1);
        chk("f2_ack_idx",  64'(ack_idx),  64'd19);
        chk("f2_id",       64'(rx_id),    64'h1FF);
        chk("f2_rtr",      64'(rx_rtr),   64'd0);
        chk("f2_dlc",      64'(rx_dlc),   64'd0);
        chk("f2_data",     rx_data,       64'd0);
        accept();
        idle(2);

        // DLC = 15 clamps to 8 bytes
        build_frame(11'h100, 1'b0, 4'd15, 64'h0807060504030201, 8, 1'b1);
        send_bits(fq.size());
        chk("f3_ack_idx", 64'(ack_idx),  64'd83);
        chk("f3_valid",   64'(rx_valid), 64'd1);
        chk("f3_dlc",     64'(rx_dlc),   64'd15);
        chk("f3_data",    rx_data,       64'h0807060504030201);
        accept();
        idle(2);

        // Dominant ACK delimiter -> form error and recovery
        ferr_cnt = 0;
        build_frame(11'h155, 1'b0, 4'd1, 64'h77, 1, 1'b0);
        send_bits(fq.size());
        idle(2);
        chk("f4_form_err_pulses", 64'(ferr_cnt), 64'd1);
        chk("f4_valid",           64'(rx_valid), 64'd0);
        chk("f4_busy_in_error",   64'(rx_busy),  64'd1);
        chk("f4_held_id",         64'(rx_id),    64'h100);
        idle(12);
        chk("f4_busy_recovered",  64'(rx_busy),  64'd0);
        build_frame(11'h1AB, 1'b0, 4'd1, 64'h5A, 1, 1'b1);
        send_bits(fq.size());
        chk("f4_after_valid", 64'(rx_valid), 64'd1);
        chk("f4_after_id",    64'(rx_id),    64'h1AB);
        chk("f4_after_data",  rx_data,       64'h5A);
        chk("f4_ferr_total",  64'(ferr_cnt), 64'd1);
        accept();
        idle(2);

        // Overrun: two frames without a handshake
        build_frame(11'h1AB, 1'b0, 4'd1, 64'h11, 1, 1'b1);
        send_bits(fq.size());
        idle(2);
        chk("f5_first_overrun", 64'(overrun), 64'd0);
        build_frame(11'h155, 1'b1, 4'd1, 64'h22, 1, 1'b1);
        send_bits(fq.size());
        chk("f5_overrun", 64'(overrun),  64'd1);
        chk("f5_valid",   64'(rx_valid), 64'd1);
        chk("f5_id",      64'(rx_id),    64'h155);
        chk("f5_data",    rx_data,       64'h22);
        accept();
        chk("f5_valid_cleared",   64'(rx_valid), 64'd0);
        chk("f5_overrun_cleared", 64'(overrun),  64'd0);
        idle(2);

        // Reset in the middle of the data field
        ferr_cnt = 0;
        build_frame(11'h1AA, 1'b0, 4'd2, 64'hBEEF, 2, 1'b1);
        send_bits(25);
        chk("f6_busy_mid", 64'(rx_busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("f6_busy",     64'(rx_busy),  64'd0);
        chk("f6_ack_tx",   64'(ack_tx),   64'd1);
        chk("f6_valid",    64'(rx_valid), 64'd0);
        chk("f6_id",       64'(rx_id),    64'd0);
        chk("f6_data",     rx_data,       64'd0);
        chk("f6_form_err", 64'(form_err), 64'd0);
        rst = 1'b0;
        idle(2);
        build_frame(11'h1AA, 1'b0, 4'd2, 64'hBEEF, 2, 1'b1);
        send_bits(fq.size());
        chk("f6_after_id",   64'(rx_id),    64'h1AA);
        chk("f6_after_data", rx_data,       64'hBEEF);
        chk("f6_no_ferr",    64'(ferr_cnt), 64'd0);
        accept();
        idle(2);

`ifdef CAN_RX_ID_FILTER_EN
        // Filter: 0x2AA rejected, 0x1AA accepted
        build_frame(11'h2AA, 1'b0, 4'd1, 64'h33, 1, 1'b1);
        send_bits(fq.size());
        idle(2);
        chk("flt_rej_ack_lows", 64'(ack_lows), 64'd0);
        chk("flt_rej_valid",    64'(rx_valid), 64'd0);
        chk("flt_rej_busy",     64'(rx_busy),  64'd0);
        build_frame(11'h1AA, 1'b0, 4'd1, 64'h44, 1, 1'b1);
        send_bits(fq.size());
        chk("flt_acc_ack_lows", 64'(ack_lows), 64'd1);
        chk("flt_acc_valid",    64'(rx_valid), 64'd1);
        chk("flt_acc_id",       64'(rx_id),    64'h1AA);
        chk("flt_acc_data",     rx_data,       64'h44);
        accept();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
